// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
// int_sequencer: pushes PC (and optionally flags) to a memory frame on
// interrupt entry, and restores them on return. Option: INT_SAVE_FLAGS_EN
// Revision: 1.0
// ============================================================================
module int_sequencer #(
  parameter logic [15:0] FRAME_ADDR = 16'h0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        manager_irq,
  input  logic [15:0] int_addr,
  input  logic        at_boundary,
  input  logic [15:0] cur_pc,
  input  logic [15:0] cur_flags,
  input  logic        rti_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_stall,
  output logic        pc_load,
  output logic [15:0] pc_val,
  output logic        flags_load,
  output logic [15:0] flags_val,
  output logic        priv_lv
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_PC  = 3'd1,
    SAVE_FLG = 3'd2,
    VECTOR   = 3'd3,
    RET_PC   = 3'd4,
    RET_FLG  = 3'd5,
    RETURN   = 3'd6
  } state_t;

`ifdef INT_SAVE_FLAGS_EN
  localparam state_t AFTER_SAVE_PC = SAVE_FLG;
  localparam state_t AFTER_RET_PC  = RET_FLG;
`else
  localparam state_t AFTER_SAVE_PC = VECTOR;
  localparam state_t AFTER_RET_PC  = RETURN;
`endif

  localparam logic [15:0] FLAGS_ADDR = FRAME_ADDR + 16'd1;

  state_t      r_state;
  state_t      w_next;
  logic        r_priv;
  logic [15:0] r_vec;
  logic [15:0] r_pc;
  logic [15:0] r_pc_val;
  logic [15:0] w_flags_word;
  logic        w_accept_int;
  logic        w_accept_rti;

  assign w_accept_int = (r_state == IDLE) && r_priv && manager_irq && at_boundary;
  assign w_accept_rti = (r_state == IDLE) && !r_priv && rti_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept_int)      w_next = SAVE_PC;
        else if (w_accept_rti) w_next = RET_PC;
      end
      SAVE_PC:  if (mem_ack) w_next = AFTER_SAVE_PC;
      SAVE_FLG: if (mem_ack) w_next = VECTOR;
      VECTOR:   w_next = IDLE;
      RET_PC:   if (mem_ack) w_next = AFTER_RET_PC;
      RET_FLG:  if (mem_ack) w_next = RETURN;
      RETURN:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Memory request fields are pure functions of state, so they hold until ack.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    case (r_state)
      SAVE_PC: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = FRAME_ADDR;
        mem_wdata = r_pc;
      end
      SAVE_FLG: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = FLAGS_ADDR;
        mem_wdata = w_flags_word;
      end
      RET_PC: begin
        mem_req  = 1'b1;
        mem_addr = FRAME_ADDR;
      end
      RET_FLG: begin
        mem_req  = 1'b1;
        mem_addr = FLAGS_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_priv   <= 1'b0;
      r_vec    <= 16'h0000;
      r_pc     <= 16'h0000;
      r_pc_val <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_accept_int) begin
        r_vec <= int_addr;
        r_pc  <= cur_pc;
      end
      if (r_state == RET_PC && mem_ack) r_pc <= mem_rdata;
      if (w_next == VECTOR && r_state != VECTOR) r_pc_val <= r_vec;
      // Without the flags word, RETURN follows RET_PC directly off the read data.
      if (w_next == RETURN && r_state != RETURN)
        r_pc_val <= (r_state == RET_PC) ? mem_rdata : r_pc;
      if (r_state == VECTOR) r_priv <= 1'b0;
      if (r_state == RETURN) r_priv <= 1'b1;
    end
  end

`ifdef INT_SAVE_FLAGS_EN
  logic [15:0] r_flags;
  logic [15:0] r_flags_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags     <= 16'h0000;
      r_flags_val <= 16'h0000;
    end else begin
      if (w_accept_int) r_flags <= cur_flags;
      if (r_state == RET_FLG && mem_ack) r_flags_val <= mem_rdata;
    end
  end

  assign w_flags_word = r_flags;
  assign flags_load   = (r_state == RETURN);
  assign flags_val    = r_flags_val;
`else
  logic unused_flags;
  assign unused_flags = ^cur_flags;
  assign w_flags_word = 16'h0000;
  assign flags_load   = 1'b0;
  assign flags_val    = 16'h0000;
`endif

  assign cpu_stall = (r_state != IDLE) || w_accept_int || w_accept_rti;
  assign pc_load   = (r_state == VECTOR) || (r_state == RETURN);
  assign pc_val    = r_pc_val;
  assign priv_lv   = (r_state == VECTOR) ? 1'b0 : r_priv;

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// Self-checking bench for int_sequencer: memory responder with programmable
// ack delay plus a frame-level reference model of entry/return behaviour.
module tb_int_sequencer;

`ifdef INT_SAVE_FLAGS_EN
  localparam int NACC = 2;
  localparam bit FLG  = 1'b1;
`else
  localparam int NACC = 1;
  localparam bit FLG  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, manager_irq, at_boundary, rti_req, mem_ack;
  logic [15:0] int_addr, cur_pc, cur_flags, mem_rdata;
  logic mem_req, mem_we, cpu_stall, pc_load, flags_load, priv_lv;
  logic [15:0] mem_addr, mem_wdata, pc_val, flags_val;

  int_sequencer #(.FRAME_ADDR(16'h0008)) dut (
    .clk(clk), .rst(rst), .manager_irq(manager_irq), .int_addr(int_addr),
    .at_boundary(at_boundary), .cur_pc(cur_pc), .cur_flags(cur_flags),
    .rti_req(rti_req), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cpu_stall(cpu_stall), .pc_load(pc_load), .pc_val(pc_val),
    .flags_load(flags_load), .flags_val(flags_val), .priv_lv(priv_lv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_model [0:15];
  int ack_delay, wcnt;
  bit force_ack;
  bit rq_active;
  logic rq_we;
  logic [15:0] rq_addr, rq_wdata;
  int log_n;
  logic log_we [8];
  logic [15:0] log_addr [8];
  logic [15:0] log_data [8];

  logic obs_mem_req, obs_stall, obs_pc_load, obs_flags_load, obs_priv;
  logic [15:0] obs_pc_val, obs_flags_val;
  logic acc_stall, cap_priv, cap_flags_load;
  logic [15:0] cap_pc_val, cap_flags_val;
  int lat;
  bit stall_ok;
  bit exp_priv;

  // One clock cycle: memory responder, then observation, then the edge.
  task automatic tick();
    #1;
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      if (rq_active) begin
        n_checks++;
        if (mem_we !== rq_we || mem_addr !== rq_addr || mem_wdata !== rq_wdata) begin
          n_fail++;
          $display("FAIL req_stable: got we=%b addr=%h wdata=%h, held we=%b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, rq_we, rq_addr, rq_wdata);
        end
      end else begin
        rq_active = 1'b1;
        rq_we = mem_we; rq_addr = mem_addr; rq_wdata = mem_wdata;
        wcnt = 0;
      end
      mem_rdata = mem_model[mem_addr[3:0]];
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        rq_active = 1'b0;
        if (log_n < 8) begin
          log_we[log_n] = mem_we; log_addr[log_n] = mem_addr; log_data[log_n] = mem_wdata;
          log_n++;
        end
        if (mem_we) mem_model[mem_addr[3:0]] = mem_wdata;
      end else begin
        wcnt++;
      end
    end else begin
      rq_active = 1'b0;
      mem_ack = force_ack || ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end
    #1;
    obs_mem_req = mem_req; obs_stall = cpu_stall; obs_pc_load = pc_load;
    obs_pc_val = pc_val; obs_flags_load = flags_load; obs_flags_val = flags_val;
    obs_priv = priv_lv;
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted entry or return and records what happened.
  task automatic run_seq(input bit is_entry, input bit both, input int d,
                         input logic [15:0] vec, input logic [15:0] pc, input logic [15:0] fl);
    ack_delay = d;
    log_n = 0;
    rti_req = both || !is_entry;
    manager_irq = both || is_entry;
    at_boundary = 1'b1;
    int_addr = vec; cur_pc = pc; cur_flags = fl;
    tick();
    acc_stall = obs_stall;
    rti_req = 1'b0; manager_irq = 1'b0;
    int_addr = 16'($urandom); cur_pc = 16'($urandom); cur_flags = 16'($urandom);
    lat = -1;
    stall_ok = 1'b1;
    for (int n = 1; n <= 80 && lat < 0; n++) begin
      tick();
      if (obs_stall !== 1'b1) stall_ok = 1'b0;
      if (obs_pc_load === 1'b1) begin
        lat = n;
        cap_pc_val = obs_pc_val; cap_priv = obs_priv;
        cap_flags_load = obs_flags_load; cap_flags_val = obs_flags_val;
      end
    end
  endtask

  task automatic test_entry(input logic [15:0] vec, input logic [15:0] pc,
                            input logic [15:0] fl, input int d, input bit both);
    int exp_lat;
    exp_lat = 1 + NACC * (d + 1);
    run_seq(1'b1, both, d, vec, pc, fl);
    n_checks++; if (acc_stall !== 1'b1) begin n_fail++; $display("FAIL entry_accept_stall: got %b expected 1", acc_stall); end
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL entry_latency: got %0d expected %0d", lat, exp_lat); end
    n_checks++; if (!stall_ok) begin n_fail++; $display("FAIL entry_stall: got gap expected stall=1 throughout"); end
    n_checks++; if (log_n != NACC) begin n_fail++; $display("FAIL entry_access_count: got %0d expected %0d", log_n, NACC); end
    n_checks++;
    if (log_n < 1 || log_we[0] !== 1'b1 || log_addr[0] !== 16'h0008 || log_data[0] !== pc) begin
      n_fail++; $display("FAIL entry_save_pc: got we=%b addr=%h data=%h expected we=1 addr=0008 data=%h",
                         log_we[0], log_addr[0], log_data[0], pc);
    end
`ifdef INT_SAVE_FLAGS_EN
    n_checks++;
    if (log_n < 2 || log_we[1] !== 1'b1 || log_addr[1] !== 16'h0009 || log_data[1] !== fl) begin
      n_fail++; $display("FAIL entry_save_flags: got we=%b addr=%h data=%h expected we=1 addr=0009 data=%h",
                         log_we[1], log_addr[1], log_data[1], fl);
    end
`endif
    n_checks++; if (cap_pc_val !== vec) begin n_fail++; $display("FAIL entry_pc_val: got %h expected %h", cap_pc_val, vec); end
    n_checks++; if (cap_priv !== 1'b0) begin n_fail++; $display("FAIL entry_priv_vector: got %b expected 0", cap_priv); end
    n_checks++; if (cap_flags_load !== 1'b0) begin n_fail++; $display("FAIL entry_flags_load: got %b expected 0", cap_flags_load); end
    tick();
    n_checks++;
    if (obs_pc_load !== 1'b0 || obs_pc_val !== vec || obs_priv !== 1'b0 || obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL entry_after: got load=%b pc_val=%h priv=%b stall=%b expected 0 %h 0 0",
                         obs_pc_load, obs_pc_val, obs_priv, obs_stall, vec);
    end
    exp_priv = 1'b0;
  endtask

  task automatic test_return(input int d, input bit both);
    int exp_lat;
    logic [15:0] epc, efl;
    exp_lat = 1 + NACC * (d + 1);
    epc = mem_model[8];
    efl = FLG ? mem_model[9] : 16'h0000;
    run_seq(1'b0, both, d, 16'($urandom), 16'($urandom), 16'($urandom));
    n_checks++; if (acc_stall !== 1'b1) begin n_fail++; $display("FAIL ret_accept_stall: got %b expected 1", acc_stall); end
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL ret_latency: got %0d expected %0d", lat, exp_lat); end
    n_checks++; if (!stall_ok) begin n_fail++; $display("FAIL ret_stall: got gap expected stall=1 throughout"); end
    n_checks++; if (log_n != NACC) begin n_fail++; $display("FAIL ret_access_count: got %0d expected %0d", log_n, NACC); end
    n_checks++;
    if (log_n < 1 || log_we[0] !== 1'b0 || log_addr[0] !== 16'h0008) begin
      n_fail++; $display("FAIL ret_read_pc: got we=%b addr=%h expected we=0 addr=0008", log_we[0], log_addr[0]);
    end
`ifdef INT_SAVE_FLAGS_EN
    n_checks++;
    if (log_n < 2 || log_we[1] !== 1'b0 || log_addr[1] !== 16'h0009) begin
      n_fail++; $display("FAIL ret_read_flags: got we=%b addr=%h expected we=0 addr=0009", log_we[1], log_addr[1]);
    end
`endif
    n_checks++; if (cap_pc_val !== epc) begin n_fail++; $display("FAIL ret_pc_val: got %h expected %h", cap_pc_val, epc); end
    n_checks++; if (cap_flags_load !== FLG) begin n_fail++; $display("FAIL ret_flags_load: got %b expected %b", cap_flags_load, FLG); end
    n_checks++; if (cap_flags_val !== efl) begin n_fail++; $display("FAIL ret_flags_val: got %h expected %h", cap_flags_val, efl); end
    n_checks++; if (cap_priv !== 1'b0) begin n_fail++; $display("FAIL ret_priv_during: got %b expected 0", cap_priv); end
    tick();
    n_checks++;
    if (obs_priv !== 1'b1 || obs_pc_load !== 1'b0 || obs_flags_load !== 1'b0 ||
        obs_pc_val !== epc || obs_flags_val !== efl) begin
      n_fail++; $display("FAIL ret_after: got priv=%b load=%b fload=%b pc=%h fl=%h expected 1 0 0 %h %h",
                         obs_priv, obs_pc_load, obs_flags_load, obs_pc_val, obs_flags_val, epc, efl);
    end
    exp_priv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs_mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h expected all 0", obs_mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if (obs_pc_load !== 1'b0 || obs_flags_load !== 1'b0 || obs_pc_val !== 16'h0 || obs_flags_val !== 16'h0) begin
      n_fail++; $display("FAIL reset_pc: got load=%b fload=%b pc=%h fl=%h expected all 0", obs_pc_load, obs_flags_load, obs_pc_val, obs_flags_val);
    end
    n_checks++;
    if (obs_priv !== 1'b0 || obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_priv_stall: got priv=%b stall=%b expected 0 0", obs_priv, obs_stall);
    end
    rst = 1'b0;
    exp_priv = 1'b0;
  endtask

  task automatic test_rti_frame();
    mem_model[8] = 16'h0400;
    test_return(0, 1'b0);
    n_checks++; if (cap_pc_val !== 16'h0400) begin n_fail++; $display("FAIL rti_frame_pc: got %h expected 0400", cap_pc_val); end
  endtask

  task automatic test_ignore();
    // priv_lv=1 here: rti_req must be ignored, and irq held without a boundary
    rti_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs_mem_req !== 1'b0 || obs_stall !== 1'b0 || obs_pc_load !== 1'b0) begin
        n_fail++; $display("FAIL rti_in_user: got req=%b stall=%b load=%b expected 0 0 0", obs_mem_req, obs_stall, obs_pc_load);
      end
    end
    rti_req = 1'b0;
    manager_irq = 1'b1; at_boundary = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs_mem_req !== 1'b0 || obs_stall !== 1'b0) begin
        n_fail++; $display("FAIL irq_no_boundary: got req=%b stall=%b expected 0 0", obs_mem_req, obs_stall);
      end
    end
    test_entry(16'h0020, 16'h0badd, 16'h00a5, 1, 1'b0);
    manager_irq = 1'b1; at_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs_mem_req !== 1'b0 || obs_stall !== 1'b0) begin
        n_fail++; $display("FAIL irq_in_sys: got req=%b stall=%b expected 0 0", obs_mem_req, obs_stall);
      end
    end
    manager_irq = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit reached;
    ack_delay = 20; log_n = 0;
    manager_irq = 1'b1; at_boundary = 1'b1;
    int_addr = 16'h0044; cur_pc = 16'h1357; cur_flags = 16'h0003;
    tick();
    manager_irq = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 40 && !reached; n++) begin
      tick();
      if (rq_active && log_n == NACC - 1) reached = 1'b1;
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL reset_mid_reach: got timeout expected final save pending"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_ack = 1'b1;
    tick();
    n_checks++;
    if (obs_mem_req !== 1'b0 || obs_priv !== 1'b0 || obs_stall !== 1'b0 || obs_pc_load !== 1'b0 || obs_pc_val !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid: got req=%b priv=%b stall=%b load=%b pc=%h expected 0 0 0 0 0000",
                         obs_mem_req, obs_priv, obs_stall, obs_pc_load, obs_pc_val);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs_mem_req !== 1'b0 || obs_pc_load !== 1'b0) begin
        n_fail++; $display("FAIL reset_late_ack: got req=%b load=%b expected 0 0", obs_mem_req, obs_pc_load);
      end
    end
    force_ack = 1'b0;
    ack_delay = 0;
    exp_priv = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      if (exp_priv)
        test_entry(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        test_return(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1; manager_irq = 1'b0; at_boundary = 1'b0; rti_req = 1'b0; mem_ack = 1'b0;
    int_addr = 16'h0; cur_pc = 16'h0; cur_flags = 16'h0; mem_rdata = 16'h0;
    force_ack = 1'b0; ack_delay = 0; wcnt = 0; rq_active = 1'b0; log_n = 0;
    rq_we = 1'b0; rq_addr = 16'h0; rq_wdata = 16'h0;
    for (int i = 0; i < 16; i++) mem_model[i] = 16'($urandom);
    @(posedge clk);
    #1;
    test_reset();
    test_rti_frame();
    test_entry(16'h0014, 16'h0123, 16'h0005, 0, 1'b0);
    test_return(0, 1'b0);
    test_entry(16'h0014, 16'h0123, 16'h0005, 3, 1'b0);
    test_return(2, 1'b1);
    test_ignore();
    test_return(1, 1'b0);
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
